// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - multi-cycle multiply/divide unit writing the hi/lo register pair
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   start, op             request from EX; op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a, src_b          operands, sampled only on the accept cycle
//   flush                 aborts any op in flight (and blocks an accept)
//   stall_req             holds the pipeline while an op is in progress
//   hi_we, lo_we          one-cycle writeback strobes (state DONE)
//   hi_wdata, lo_wdata    hi = product upper / remainder, lo = product lower / quotient
//
// Configuration macro: MULDIV_ITER_MULT_EN
//   defined   -> 32-cycle shift-add multiply in state MUL (same latency as divide)
//   undefined -> single-cycle combinational multiply registered at accept, IDLE->DONE

module hilo_muldiv (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_req,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] acc_hi;     // remainder / product upper
    logic [31:0] acc_lo;     // dividend->quotient / multiplier->product lower
    logic [31:0] operand_b;  // divisor or multiplicand magnitude
    logic [4:0]  count;
    logic        is_div;
    logic        neg_lo;
    logic        neg_hi;
    logic        div_zero;

    logic        accept;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    assign accept = (state == IDLE) && start && !flush;
    assign sign_a = !op[0] && src_a[31];
    assign sign_b = !op[0] && src_b[31];
    assign mag_a  = sign_a ? -src_a : src_a;
    assign mag_b  = sign_b ? -src_b : src_b;

    // Restoring divide step. When the shifted remainder is >= divisor the
    // difference always fits in 32 bits, so a 32-bit subtract suffices.
    logic [32:0] rem_shift;
    logic        div_ge;
    logic [31:0] div_diff;

    assign rem_shift = {acc_hi, acc_lo[31]};
    assign div_ge    = rem_shift >= {1'b0, operand_b};
    assign div_diff  = rem_shift[31:0] - operand_b;

`ifdef MULDIV_ITER_MULT_EN
    // Shift-add step: add multiplicand when the multiplier LSB is set, then
    // shift the 65-bit {carry, hi, lo} right by one.
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : 33'd0);
`else
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    assign ext_a   = {(op[0] ? 32'd0 : {32{src_a[31]}}), src_a};
    assign ext_b   = {(op[0] ? 32'd0 : {32{src_b[31]}}), src_b};
    assign product = ext_a * ext_b;
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MULDIV_ITER_MULT_EN
                    state_next = op[1] ? DIV : MUL;
`else
                    state_next = op[1] ? DIV : DONE;
`endif
                end
            end
            MUL, DIV: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (count == 5'd31) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_hi    <= 32'd0;
            acc_lo    <= 32'd0;
            operand_b <= 32'd0;
            count     <= 5'd0;
            is_div    <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            count    <= 5'd0;
            is_div   <= op[1];
            div_zero <= op[1] && (src_b == 32'd0);
            if (op[1]) begin
                acc_hi    <= 32'd0;
                acc_lo    <= mag_a;
                operand_b <= mag_b;
                neg_lo    <= sign_a ^ sign_b;
                neg_hi    <= sign_a;
            end else begin
`ifdef MULDIV_ITER_MULT_EN
                acc_hi    <= 32'd0;
                acc_lo    <= mag_a;
                operand_b <= mag_b;
                neg_lo    <= sign_a ^ sign_b;
                neg_hi    <= 1'b0;
`else
                {acc_hi, acc_lo} <= product;
                operand_b <= 32'd0;
                neg_lo    <= 1'b0;
                neg_hi    <= 1'b0;
`endif
            end
        end else if (state == DIV) begin
            count  <= count + 5'd1;
            acc_hi <= div_ge ? div_diff : rem_shift[31:0];
            acc_lo <= {acc_lo[30:0], div_ge};
`ifdef MULDIV_ITER_MULT_EN
        end else if (state == MUL) begin
            count            <= count + 5'd1;
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[31:1]};
`endif
        end
    end

    // Sign fix-up applied to the final magnitudes
    logic [63:0] prod_neg;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign prod_neg = -{acc_hi, acc_lo};

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        if (is_div) begin
            // Divide by zero: quotient all ones; remainder magnitude equals
            // |a|, so the normal sign fix restores src_a.
            res_hi = neg_hi ? -acc_hi : acc_hi;
            res_lo = div_zero ? 32'hFFFF_FFFF : (neg_lo ? -acc_lo : acc_lo);
        end else begin
            {res_hi, res_lo} = neg_lo ? prod_neg : {acc_hi, acc_lo};
        end
    end

    // Outputs; gated by resetn so stall_req cannot follow start during reset
    always_comb begin
        stall_req = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        hi_wdata  = 32'd0;
        lo_wdata  = 32'd0;
        if (resetn) begin
            stall_req = accept || (state == MUL) || (state == DIV);
            if (state == DONE) begin
                hi_we    = 1'b1;
                lo_we    = 1'b1;
                hi_wdata = res_hi;
                lo_wdata = res_lo;
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - directed self-checking bench for hilo_muldiv

module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef MULDIV_ITER_MULT_EN
    localparam int MUL_LAT = 33;
`else
    localparam int MUL_LAT = 1;
`endif
    localparam int DIV_LAT = 33;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    hilo_muldiv dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .stall_req (stall_req),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .hi_wdata  (hi_wdata),
        .lo_wdata  (lo_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Issues one op at the next negedge (cycle 0) and follows it to DONE.
    // Returns at the negedge of the DONE cycle so a following call lands
    // on the cycle right after DONE (back-to-back accept).
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_lat);
        int lat;
        int stall_bad;
        int leak;
        lat       = 0;
        stall_bad = 0;
        leak      = 0;
        @(negedge clk);
        check({tag, ".we_c0"}, 64'(hi_we | lo_we), 64'd0);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        #1;
        check({tag, ".stall_c0"}, 64'(stall_req), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        src_a = 32'hDEAD_BEEF;
        src_b = 32'h1234_5678;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (hi_we) begin
                lat = k;
                break;
            end
            if (!stall_req) stall_bad++;
            if (lo_we || hi_wdata != 32'd0 || lo_wdata != 32'd0) leak++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".hi"}, 64'(hi_wdata), 64'(exp_hi));
        check({tag, ".lo"}, 64'(lo_wdata), 64'(exp_lo));
        check({tag, ".lo_we"}, 64'(lo_we), 64'd1);
        check({tag, ".stall_done"}, 64'(stall_req), 64'd0);
        check({tag, ".stall_busy"}, 64'(stall_bad), 64'd0);
        check({tag, ".idle_outputs"}, 64'(leak), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int leak;
        resetn = 1'b0;
        start  = 1'b1;
        flush  = 1'b0;
        op     = OP_DIVU;
        src_a  = 32'd100;
        src_b  = 32'd7;
        repeat (2) @(negedge clk);
        check("reset.stall", 64'(stall_req), 64'd0);
        check("reset.we", 64'({hi_we, lo_we}), 64'd0);
        check("reset.wdata", {hi_wdata, lo_wdata}, 64'd0);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        run_op("divu_100_7",   OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        DIV_LAT);
        run_op("div_m7_2",     OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        run_op("mult_m1_2",    OP_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("multu_m1_2",   OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE, MUL_LAT);
        run_op("divu_5_0",     OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, DIV_LAT);
        run_op("div_min_m1",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV_LAT);
        run_op("div_7_m2",     OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DIV_LAT);
        run_op("div_m8_0",     OP_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, DIV_LAT);
        run_op("divu_max_1",   OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, DIV_LAT);
        run_op("mult_min_min", OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         MUL_LAT);
        run_op("multu_max",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         MUL_LAT);

        // start together with flush in IDLE is not accepted
        leak = 0;
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = OP_DIVU;
        #1;
        check("flush_idle.stall", 64'(stall_req), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (hi_we || lo_we || stall_req) leak++;
        end
        check("flush_idle.no_op", 64'(leak), 64'd0);

        // flush at cycle 10 of a DIVU, restart at cycle 12 -> done at 45
        leak = 0;
        @(negedge clk);
        start = 1'b1;
        op    = OP_DIVU;
        src_a = 32'd100;
        src_b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (hi_we || lo_we) leak++;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_div.idle_c11", 64'({stall_req, hi_we, lo_we}), 64'd0);
        check("flush_div.no_strobe", 64'(leak), 64'd0);
        run_op("flush_restart", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);

        // reset pulsed at cycle 5 of a DIV
        leak = 0;
        @(negedge clk);
        start = 1'b1;
        op    = OP_DIV;
        src_a = 32'hFFFF_FFF9;
        src_b = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_mid.stall", 64'(stall_req), 64'd0);
        check("rst_mid.we", 64'({hi_we, lo_we}), 64'd0);
        check("rst_mid.wdata", {hi_wdata, lo_wdata}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (hi_we || lo_we || stall_req) leak++;
        end
        check("rst_mid.no_strobe", 64'(leak), 64'd0);
        run_op("after_reset", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
